alu_ctrl_issue: RTL

Issue stage that drives the ALU's 3-bit operation select. Accepts decoded instruction fields (ALUOp, funct7, funct3) over a valid/ready handshake and encodes them into the ALU control code. Holds the code in a one-entry output register until the execute stage consumes it. Because the multiplier is multi-cycle, it blocks new issue for a programmable number of cycles after each MUL.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_ctrl_decode.sv | 43 ++++
 rtl/alu_ctrl_issue.sv | 111 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control issue stage: ALU op codes, ALUOp
// classes, funct7/funct3 values and the issue FSM state type.
package alu_pkg;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_SUM  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;
   localparam logic [2:0] ALU_AND  = 3'b011;
   localparam logic [2:0] ALU_OR   = 3'b100;
   localparam logic [2:0] ALU_XOR  = 3'b101;
   localparam logic [2:0] ALU_MUL  = 3'b110;

   localparam logic [1:0] OP_LDST   = 2'b00;
   localparam logic [1:0] OP_BRANCH = 2'b01;
   localparam logic [1:0] OP_RTYPE  = 2'b10;
   localparam logic [1:0] OP_ITYPE  = 2'b11;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_HOLD  = 2'b01,
      ST_BUSY  = 2'b10
   } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of ALUOp/funct7/funct3 into the 3-bit ALU op code.
// Unsupported encodings yield PASS with the illegal flag raised.
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [6:0] funct7,
   input  logic [2:0] funct3,
   output logic [2:0] code,
   output logic       illegal
);

   always_comb begin
      code    = ALU_PASS;
      illegal = 1'b0;
      case (alu_op)
         OP_LDST:   code = ALU_SUM;
         OP_BRANCH: code = ALU_SUB;
         OP_RTYPE: begin
            case ({funct7, funct3})
               {F7_BASE,   F3_ADD}: code = ALU_SUM;
               {F7_ALT,    F3_ADD}: code = ALU_SUB;
               {F7_MULDIV, F3_ADD}: code = ALU_MUL;
               {F7_BASE,   F3_AND}: code = ALU_AND;
               {F7_BASE,   F3_OR }: code = ALU_OR;
               {F7_BASE,   F3_XOR}: code = ALU_XOR;
               default:             illegal = 1'b1;
            endcase
         end
         default: begin
            // I-type arithmetic: funct7 holds immediate bits, so it is ignored
            case (funct3)
               F3_ADD:  code = ALU_SUM;
               F3_AND:  code = ALU_AND;
               F3_OR:   code = ALU_OR;
               F3_XOR:  code = ALU_XOR;
               default: illegal = 1'b1;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/alu_ctrl_issue.sv
// Issue stage: one-entry output register holding the ALU code, 1-cycle latency,
// full throughput for non-MUL; after a MUL is consumed, issue blocks MUL_LAT-1 cycles.
module alu_ctrl_issue
   import alu_pkg::*;
#(
   parameter int MUL_LAT = 3
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  logic [1:0] ALUOp_i,
   input  logic [6:0] funct7_i,
   input  logic [2:0] funct3_i,
   output logic       out_valid_o,
   input  logic       out_ready_i,
   output logic [2:0] ALUCtrl_o,
   output logic       illegal_o
);

   localparam logic [3:0] MUL_CNT    = 4'(MUL_LAT - 1);
   localparam bit         MUL_STALLS = (MUL_LAT > 1);

   state_t     state;
   state_t     state_n;
   logic [3:0] cnt;
   logic [3:0] cnt_n;
   logic [2:0] ctrl;
   logic       ill;
   logic [2:0] dec_code;
   logic       dec_ill;
   logic       held_mul;
   logic       ready;
   logic       load;

   alu_ctrl_decode u_decode (
      .alu_op  (ALUOp_i),
      .funct7  (funct7_i),
      .funct3  (funct3_i),
      .code    (dec_code),
      .illegal (dec_ill)
   );

   assign held_mul = MUL_STALLS && (ctrl == ALU_MUL);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ready   = 1'b0;
      load    = 1'b0;
      case (state)
         ST_EMPTY: begin
            ready = 1'b1;
            if (in_valid_i) begin
               load    = 1'b1;
               state_n = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (out_ready_i) begin
               if (held_mul) begin
                  state_n = ST_BUSY;
                  cnt_n   = MUL_CNT;
               end else begin
                  // consume and refill in the same cycle keeps 1 beat/cycle
                  ready = 1'b1;
                  if (in_valid_i) begin
                     load = 1'b1;
                  end else begin
                     state_n = ST_EMPTY;
                  end
               end
            end
         end
         ST_BUSY: begin
            if (cnt <= 4'd1) begin
               cnt_n   = 4'd0;
               state_n = ST_EMPTY;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         default: begin
            state_n = ST_EMPTY;
            cnt_n   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_EMPTY;
         cnt   <= 4'd0;
         ctrl  <= ALU_PASS;
         ill   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (load) begin
            ctrl <= dec_code;
            ill  <= dec_ill;
         end
      end
   end

   assign in_ready_o  = ready;
   assign out_valid_o = (state == ST_HOLD);
   assign ALUCtrl_o   = ctrl;
   assign illegal_o   = ill;

endmodule
